// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sub-word bridge: funct3 encodings,
// FSM state type and the request legality check.
package lsu_pkg;

    localparam int LSU_DATA_W = 32;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Size/sign must exist for the direction, and the address must be
    // naturally aligned to the access size. Unsigned variants are load-only.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !we;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !we && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering between a little-endian 32-bit memory word and
// the core: extracts/extends load data and merges store data into the word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    input  logic [LSU_DATA_W-1:0] i_mem_word,
    input  logic [LSU_DATA_W-1:0] i_store_data,
    output logic [LSU_DATA_W-1:0] o_load_data,
    output logic [LSU_DATA_W-1:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Addressed byte lane k sits at [8k+7:8k]; half lane at [16h+15:16h]
    assign w_byte = i_mem_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_mem_word[{i_addr_lo[1], 4'b0000} +: 16];

    // Load path: sign or zero extend the selected lane to a full word
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no branch can leave it unassigned and infer a latch.
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'h0000, w_half};
            F3_W:    o_load_data = i_mem_word;
            default: o_load_data = '0;
        endcase
    end

    // Store path: replace only the addressed lane of the current memory word
    always_comb begin
        o_store_word = i_mem_word;
        case (i_funct3)
            F3_B:    o_store_word[{i_addr_lo, 3'b000} +: 8]    = i_store_data[7:0];
            F3_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_store_data[15:0];
            F3_W:    o_store_word = i_store_data;
            default: o_store_word = i_mem_word;
        endcase
    end

endmodule

// File: rtl/lsu_subword_bridge.sv
// Load/store unit in front of a word-only DataMemory. Loads read one word and
// extract a lane; stores read-modify-write the containing word. Misaligned or
// illegal requests complete immediately with an error and touch no memory.
module lsu_subword_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_WD,
    input  logic [DATA_W-1:0] mem_RD
);

    lsu_state_t        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wd;

    logic              w_req_legal;
    logic              w_accept;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_store_word;

    assign w_req_legal = is_legal(req_we, req_funct3, req_addr[1:0]);
    assign w_accept    = req_valid && (r_state == IDLE);

    // The latched address drives DataMemory from ACCESS through WRITE, so the
    // read and the write of a store always hit the same word.
    assign mem_A      = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_WE     = r_mem_we;
    assign mem_WD     = r_mem_wd;
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    lsu_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_mem_word   (mem_RD),
        .i_store_data (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // Request FSM with registered response and memory-control outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wd     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the pre-edge values, independent of statement order.
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_mem_we     <= 1'b0;
                    if (w_accept) begin
                        r_we         <= req_we;
                        r_funct3     <= req_funct3;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_resp_rdata <= '0;
                        if (w_req_legal) begin
                            r_resp_err <= 1'b0;
                            r_state    <= ACCESS;
                        end else begin
                            r_resp_err   <= 1'b1;
                            r_resp_valid <= 1'b1;
                            r_state      <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_mem_wd <= w_store_word;
                        r_mem_we <= 1'b1;
                        r_state  <= WRITE;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= RESP;
                    end
                end
                WRITE: begin
                    // DataMemory commits on this edge; drop WE right after it
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword_bridge.sv
// Directed self-checking bench for lsu_subword_bridge with a behavioural
// word-wide DataMemory (combinational read, write on clock edge).
module tb_lsu_subword_bridge;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    // DataMemory model: 256 words, indexed by word address bits [9:2]
    logic [31:0] mem [0:255];
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    int          we_pulses;
    int          we_cyc;
    int          resp_cyc;
    logic [31:0] got_rdata;
    logic [31:0] got_wd;
    logic        got_err;

    bit exp_rdy  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_resp [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we)       mem[pl_idx]      <= pl_data;
        else if (mem_WE) mem[mem_A[9:2]]  <= mem_WD;
    end

    assign mem_RD = mem[mem_A[9:2]];

    lsu_subword_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one request from IDLE (called #1 after an edge) and follow it to
    // its response; latencies are counted from the accept edge.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic [31:0] exp_wd);
        logic exp_we;
        exp_we = we && !exp_err;
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        we_pulses  = 0;
        we_cyc     = -1;
        resp_cyc   = -1;
        got_wd     = 32'h0;
        got_rdata  = 32'hFFFF_FFFF;
        got_err    = 1'bx;
        for (int n = 1; n <= 8 && resp_cyc < 0; n++) begin
            if (mem_WE) begin
                we_pulses++;
                we_cyc = n;
                got_wd = mem_WD;
            end
            if (resp_valid) begin
                resp_cyc  = n;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
            check({tag, " ready_busy"}, 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, " resp_cycle"}, 32'(resp_cyc), 32'(exp_lat));
        check({tag, " rdata"},      got_rdata,      exp_rdata);
        check({tag, " err"},        32'(got_err),   32'(exp_err));
        check({tag, " we_pulses"},  32'(we_pulses), exp_we ? 32'd1 : 32'd0);
        check({tag, " we_cycle"},   32'(we_cyc),    exp_we ? 32'(exp_lat - 1) : 32'hFFFF_FFFF);
        check({tag, " mem_wd"},     got_wd,         exp_wd);
        check({tag, " resp_drop"},  32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        pl_we      = 1'b1;
        pl_idx     = 8'h40;           // byte address 0x100
        pl_data    = 32'h8899_AABB;
        @(posedge clk); #1;
        pl_idx     = 8'h80;           // byte address 0x200
        pl_data    = 32'h0102_0304;
        @(posedge clk); #1;
        pl_we      = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata,      32'h0);
        check("rst resp_err",   32'(resp_err),   32'd0);
        check("rst mem_WE",     32'(mem_WE),     32'd0);
        check("rst mem_WD",     mem_WD,          32'h0);
        check("rst mem_A",      mem_A,           32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst req_ready",  32'(req_ready),  32'd1);

        // Loads from 0x8899AABB
        run_req("lb_101",  1'b0, F3_B,  32'h101, 32'h0, 2, 32'hFFFF_FFAA, 1'b0, 32'h0);
        run_req("lbu_101", 1'b0, F3_BU, 32'h101, 32'h0, 2, 32'h0000_00AA, 1'b0, 32'h0);
        run_req("lh_102",  1'b0, F3_H,  32'h102, 32'h0, 2, 32'hFFFF_8899, 1'b0, 32'h0);
        run_req("lhu_100", 1'b0, F3_HU, 32'h100, 32'h0, 2, 32'h0000_AABB, 1'b0, 32'h0);
        run_req("lw_100",  1'b0, F3_W,  32'h100, 32'h0, 2, 32'h8899_AABB, 1'b0, 32'h0);

        // Stores via read-modify-write
        run_req("sb_103",  1'b1, F3_B,  32'h103, 32'h1234_5677, 3, 32'h0, 1'b0, 32'h7799_AABB);
        check("sb_103 mem", mem[8'h40], 32'h7799_AABB);
        run_req("sh_100",  1'b1, F3_H,  32'h100, 32'h0000_CAFE, 3, 32'h0, 1'b0, 32'h7799_CAFE);
        check("sh_100 mem", mem[8'h40], 32'h7799_CAFE);
        run_req("lw_back", 1'b0, F3_W,  32'h100, 32'h0, 2, 32'h7799_CAFE, 1'b0, 32'h0);

        // Error cases: respond in cycle 1, no memory access
        run_req("err_lw_102", 1'b0, F3_W,   32'h102, 32'h0,         1, 32'h0, 1'b1, 32'h0);
        run_req("err_sh_101", 1'b1, F3_H,   32'h101, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 32'h0);
        run_req("err_f3_011", 1'b0, 3'b011, 32'h100, 32'h0,         1, 32'h0, 1'b1, 32'h0);
        check("err mem_unchanged", mem[8'h40], 32'h7799_CAFE);

        // Reset while an SW is in ACCESS: must abort without writing
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h200;
        req_wdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        check("abort in_access", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort idle",   32'(req_ready),  32'd1);
        check("abort mem_WE", 32'(mem_WE),     32'd0);
        check("abort rdata",  resp_rdata,      32'h0);
        for (int k = 0; k < 4; k++) begin
            check("abort no_resp", 32'(resp_valid), 32'd0);
            check("abort no_we",   32'(mem_WE),     32'd0);
            @(posedge clk); #1;
        end
        check("abort mem_200", mem[8'h80], 32'h0102_0304);

        // Back-to-back: req_valid held high; changes outside IDLE are ignored
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h100;
        for (int k = 0; k < 8; k++) begin
            check("b2b ready", 32'(req_ready),  32'(exp_rdy[k]));
            check("b2b resp",  32'(resp_valid), 32'(exp_resp[k]));
            if (k == 2) check("b2b rdata_lw",  resp_rdata, 32'h7799_CAFE);
            if (k == 5) check("b2b rdata_lbu", resp_rdata, 32'h0000_00CA);
            if (k == 1) begin
                req_funct3 = F3_BU;
                req_addr   = 32'h101;
            end
            if (k == 4) req_valid = 1'b0;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
